// File: rtl/switch_input_unit_pkg.sv
// rtl/switch_input_unit_pkg.sv - shared IO-space constants for the switch input unit
//
// Purpose : register offsets of the switch peripheral, the switch-space page
//           selector used by the memory/IO mux, and an offset decoder.
// Ports   : none (package).
package switch_input_unit_pkg;

  localparam logic [3:0] SW_OFF_DATA = 4'h0;
  localparam logic [3:0] SW_OFF_STAT = 4'h2;
  localparam logic [3:0] SW_OFF_LIVE = 4'h4;
  localparam logic [3:0] SW_PAGE     = 4'h7;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_LIVE = 2'd2,
    REG_NONE = 2'd3
  } sw_reg_e;

  function automatic sw_reg_e decode_offset(input logic [3:0] off);
    case (off)
      SW_OFF_DATA: decode_offset = REG_DATA;
      SW_OFF_STAT: decode_offset = REG_STAT;
      SW_OFF_LIVE: decode_offset = REG_LIVE;
      default:     decode_offset = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/switch_input_unit_debounce.sv
// rtl/switch_input_unit_debounce.sv - two-flop synchronizer plus vector debouncer
//
// Purpose : synchronizes a raw asynchronous vector and accepts a new value
//           only after it has been steady for DEBOUNCE_CYCLES clocks. Any bit
//           toggling restarts the count for the whole vector.
// Ports   : clk, rst_n (async active-low), raw[WIDTH-1:0] (asynchronous in),
//           stable[WIDTH-1:0] (debounced out).
module debounce_unit
  import switch_input_unit_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    meta_d   = raw;
    sync_d   = meta_q;
    prev_d   = sync_q;
    stable_d = stable_q;
    count_d  = '0;
    // Count only while the synchronized value is both steady and different
    // from the accepted one; the count stops at CNT_MAX so it cannot wrap.
    if (sync_q == prev_q && sync_q != stable_q) begin
      if (count_q == CNT_MAX) begin
        stable_d = sync_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      count_q  <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_input_unit.sv
// rtl/switch_input_unit.sv - memory-mapped switch/button input peripheral
//
// Purpose : debounces 16 board switches and a confirm button; a debounced
//           confirm press latches a switch snapshot and sets a read-to-clear
//           valid flag. Read data is combinational for the single-cycle load.
// Config  : SWITCH_SNAPSHOT_EN enables the button, snapshot register and
//           snap_valid; without it offset 0x0 returns the live switches.
// Ports   : clk, rst_n (async active-low), SwitchCtrl (chip select),
//           addr_low[3:0] (register offset), sw_raw[15:0], btn_confirm_raw,
//           io_rdata[15:0] (read data to mux), snap_valid (LED debug).
module switch_input_unit
  import switch_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SwitchCtrl,
  input  logic [3:0]  addr_low,
  input  logic [15:0] sw_raw,
  input  logic        btn_confirm_raw,
  output logic [15:0] io_rdata,
  output logic        snap_valid
);

  logic [15:0] sw_stable;
  sw_reg_e     reg_sel;

  assign reg_sel = decode_offset(addr_low);

  debounce_unit #(
    .WIDTH           (16),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sw_raw),
    .stable (sw_stable)
  );

`ifdef SWITCH_SNAPSHOT_EN
  logic        btn_stable;
  logic        btn_prev_q, btn_prev_d;
  logic [15:0] snapshot_q, snapshot_d;
  logic        snap_valid_q, snap_valid_d;
  logic        confirm_pulse;
  logic        data_read;

  debounce_unit #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_confirm_raw),
    .stable (btn_stable)
  );

  assign confirm_pulse = btn_stable & ~btn_prev_q;
  assign data_read     = SwitchCtrl && (reg_sel == REG_DATA);

  always_comb begin
    btn_prev_d   = btn_stable;
    snapshot_d   = snapshot_q;
    snap_valid_d = snap_valid_q;
    // A new snapshot beats a same-cycle read-clear; the read still sees
    // the previous snapshot because io_rdata comes from snapshot_q.
    if (confirm_pulse) begin
      snapshot_d   = sw_stable;
      snap_valid_d = 1'b1;
    end else if (data_read) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q   <= 1'b0;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      btn_prev_q   <= btn_prev_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_valid = snap_valid_q;

  always_comb begin
    io_rdata = '0;
    if (SwitchCtrl) begin
      case (reg_sel)
        REG_DATA: io_rdata = snapshot_q;
        REG_STAT: io_rdata = {15'b0, snap_valid_q};
        REG_LIVE: io_rdata = sw_stable;
        default:  io_rdata = '0;
      endcase
    end
  end
`else
  logic unused_btn;
  assign unused_btn = btn_confirm_raw;
  assign snap_valid = 1'b0;

  always_comb begin
    io_rdata = '0;
    if (SwitchCtrl) begin
      case (reg_sel)
        REG_DATA: io_rdata = sw_stable;
        REG_LIVE: io_rdata = sw_stable;
        default:  io_rdata = '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_switch_input_unit.sv
// tb/tb_switch_input_unit.sv - scoreboard bench for switch_input_unit
module tb_switch_input_unit;

`ifdef SWITCH_SNAPSHOT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SwitchCtrl = 1'b0;
  logic [3:0]  addr_low = 4'h0;
  logic [15:0] sw_raw = 16'h0000;
  logic        btn_confirm_raw = 1'b0;
  logic [15:0] io_rdata;
  logic        snap_valid;

  logic probe_rd  = 1'b0;
  logic probe_led = 1'b0;
  logic end_req   = 1'b0;

  typedef struct {
    bit          is_led;
    logic [15:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_input_unit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .SwitchCtrl      (SwitchCtrl),
    .addr_low        (addr_low),
    .sw_raw          (sw_raw),
    .btn_confirm_raw (btn_confirm_raw),
    .io_rdata        (io_rdata),
    .snap_valid      (snap_valid)
  );

  // Monitor: pops one expectation per presented read or LED probe.
  sb_entry_t e;
  always @(negedge clk) begin
    if (SwitchCtrl || probe_rd) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: rdata=%h with no expectation", io_rdata);
      end else begin
        e = sb.pop_front();
        if (e.is_led || io_rdata !== e.exp) begin
          n_err++;
          $display("FAIL %s: io_rdata got %h want %h", e.name, io_rdata, e.exp);
        end
      end
    end
    if (probe_led) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: snap_valid=%b with no expectation", snap_valid);
      end else begin
        e = sb.pop_front();
        if (!e.is_led || snap_valid !== e.exp[0]) begin
          n_err++;
          $display("FAIL %s: snap_valid got %b want %b", e.name, snap_valid, e.exp[0]);
        end
      end
    end
    if (end_req) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_led, input logic [15:0] exp, input string nm);
    sb_entry_t x;
    x.is_led = is_led;
    x.exp    = exp;
    x.name   = nm;
    sb.push_back(x);
  endtask

  task automatic rd(input logic [3:0] off, input logic [15:0] exp, input string nm);
    push(1'b0, exp, nm);
    SwitchCtrl = 1'b1;
    addr_low   = off;
    tick();
    SwitchCtrl = 1'b0;
  endtask

  task automatic led(input logic exp, input string nm);
    push(1'b1, {15'b0, exp}, nm);
    probe_led = 1'b1;
    tick();
    probe_led = 1'b0;
  endtask

  // Call right after changing an input just past an edge; reads offset 0x4
  // after edges 1..7 and expects the new value from edge 7 only.
  task automatic latency(input logic [15:0] old_v, input logic [15:0] new_v, input string nm);
    tick();
    SwitchCtrl = 1'b1;
    addr_low   = 4'h4;
    for (int n = 1; n <= 7; n++) begin
      push(1'b0, (n < 7) ? old_v : new_v, nm);
      tick();
    end
    SwitchCtrl = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    rd(4'h0, 16'h0000, "rst_data");
    rd(4'h2, 16'h0000, "rst_stat");
    rd(4'h4, 16'h0000, "rst_live");
    led(1'b0, "rst_led");
    rst_n = 1'b1;

    // Reset mid-run with switches high, then full requalification
    sw_raw = 16'hFFFF;
    repeat (12) tick();
    rd(4'h4, 16'hFFFF, "pre_rst_live");
    rst_n = 1'b0;
    tick();
    rd(4'h0, 16'h0000, "midrst_data");
    rd(4'h2, 16'h0000, "midrst_stat");
    rd(4'h4, 16'h0000, "midrst_live");
    rst_n = 1'b1;
    latency(16'h0000, 16'hFFFF, "rst_latency");

    // Switch latency
    sw_raw = 16'hA5C3;
    latency(16'hFFFF, 16'hA5C3, "sw_latency");

    // Glitch rejection on bit 0
    sw_raw = 16'hA5C2;
    repeat (10) tick();
    SwitchCtrl = 1'b1;
    addr_low   = 4'h4;
    for (int n = 0; n < 14; n++) begin
      sw_raw = (n >= 1 && n <= 3) ? 16'hA5C3 : 16'hA5C2;
      push(1'b0, 16'hA5C2, "glitch_live");
      tick();
    end
    SwitchCtrl = 1'b0;

    // Snapshot and read-to-clear
    sw_raw = 16'h1234;
    repeat (10) tick();
    btn_confirm_raw = 1'b1;
    repeat (10) tick();
    btn_confirm_raw = 1'b0;
    repeat (10) tick();
    led(EN, "snap_led_set");
    rd(4'h2, EN ? 16'h0001 : 16'h0000, "snap_stat_set");
    rd(4'h0, 16'h1234, "snap_data");
    rd(4'h2, 16'h0000, "snap_stat_clr");
    led(1'b0, "snap_led_clr");

    // Set wins over a same-cycle data read; then held button gives no repeat
    sw_raw = 16'h5678;
    repeat (10) tick();
    btn_confirm_raw = 1'b1;
    repeat (7) tick();
    rd(4'h0, EN ? 16'h1234 : 16'h5678, "setwin_old_data");
    led(EN, "setwin_led");
    rd(4'h0, 16'h5678, "setwin_new_data");
    repeat (10) tick();
    led(1'b0, "held_no_repeat");
    btn_confirm_raw = 1'b0;
    repeat (10) tick();

    // Chip select and unmapped offsets
    btn_confirm_raw = 1'b1;
    repeat (10) tick();
    btn_confirm_raw = 1'b0;
    repeat (10) tick();
    led(EN, "cs_led_before");
    addr_low = 4'h0;
    push(1'b0, 16'h0000, "cs_low_rdata");
    probe_rd = 1'b1;
    tick();
    probe_rd = 1'b0;
    led(EN, "cs_low_led_kept");
    rd(4'h6, 16'h0000, "unmapped_6");
    rd(4'hF, 16'h0000, "unmapped_f");
    rd(4'h2, EN ? 16'h0001 : 16'h0000, "cs_stat_kept");

    end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end_timeout: monitor did not finish");
    $fatal(1);
  end

endmodule

// File: doc/switch_input_unit.md
# switch_input_unit

Memory-mapped switch/button input peripheral for the single-cycle CPU's IO space. It synchronizes and debounces the 16 board switches and a confirm button. On each debounced confirm press it latches a snapshot of the switches and sets a read-to-clear valid flag. It sits directly upstream of the memory/IO mux: it drives the 16-bit `io_rdata` that the mux zero-extends into the register file, and is selected by the mux's `SwitchCtrl` chip select.

## Interface
- `DEBOUNCE_CYCLES`, 230000 — clock cycles an input must hold steady before it is accepted (about 10 ms at 23 MHz); minimum 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)` — debounce counter width.
- `clk` input 1 — single system clock; all state changes on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `SwitchCtrl` input 1 — chip select from the memory/IO mux; high for the one cycle of a load in switch space.
- `addr_low` input 4 — `addr_in[3:0]`, register offset.
- `sw_raw` input 16 — raw board switches, asynchronous.
- `btn_confirm_raw` input 1 — raw confirm button, active high, asynchronous.
- `io_rdata` output 16 — read data to the memory/IO mux.
- `snap_valid` output 1 — snapshot-valid flag, intended for board LED debug.

## Operation
- **Input synchronizers:** two-flop synchronizer on every raw bit; downstream logic sees only synchronized values.
- **Per-vector debounce (switches, then button separately):**
  - Keep `sync_prev`, `stable` and `count`.
  - If `sync != sync_prev`: `count <= 0`.
  - Else if `sync != stable`:
    - if `count == DEBOUNCE_CYCLES-1`: `stable <= sync`, `count <= 0`;
    - otherwise `count++`.
  - Else: `count <= 0`.
  - Any bit toggling restarts the whole vector's count.
- **Confirm edge:** a 0→1 transition of the debounced button produces a one-cycle `confirm_pulse`. On that pulse, `snapshot <= sw_stable` and `snap_valid <= 1`.
- **Register map** (read-only; `io_rdata` is combinational, zero latency, so the single-cycle load completes in the same cycle):
  - `0x0`: snapshot data. The read clears `snap_valid` at the clock edge ending the access.
  - `0x2`: status, `{15'b0, snap_valid}`.
  - `0x4`: live debounced switches, `sw_stable`.
  - Other offsets: `16'h0000`.
- `SwitchCtrl` low → `io_rdata = 16'h0000`, and no side effects.
- **Simultaneous snapshot read and `confirm_pulse`:** the set wins. `snapshot` takes the new value, `snap_valid` stays 1, and the same-cycle read returns the old snapshot.
- Writes do not exist; `ioWrite` is not an input.

## Timing
- **Reset values:** all synchronizer flops, `stable`, `snapshot`, `count` and `snap_valid` reset to 0. `io_rdata` is therefore 0.
- **Switch latency:** a raw switch change held steady is visible at offset `0x4` exactly `DEBOUNCE_CYCLES+3` rising edges after it is first sampled. That is 2 edges of synchronizer, 1 edge of `sync_prev`, then `DEBOUNCE_CYCLES` edges of counting.
- **Snapshot latency:** a raw button press held steady sets `snap_valid` one edge after the button's `stable` rises.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- **Counter bound:** the counter never wraps; it saturates by construction at `DEBOUNCE_CYCLES-1`.
- **Reset mid-debounce:** the count is discarded; the input must re-qualify for the full period after release.
- **Held button:** holding the button produces exactly one pulse. A new pulse requires a debounced release followed by a debounced press.

## Configuration
- `SWITCH_SNAPSHOT_EN` defined: confirm button, snapshot register and `snap_valid` behave as above.
- Not defined:
  - no button logic and no snapshot register;
  - offset `0x0` returns `sw_stable`;
  - offset `0x2` returns 0;
  - `snap_valid` is tied to 0;
  - `btn_confirm_raw` is unused.

## Structure
- **Shared IO package:** register offsets `SW_OFF_DATA=4'h0`, `SW_OFF_STAT=4'h2` and `SW_OFF_LIVE=4'h4`, plus the switch-space selector `SW_PAGE=4'h7` used by the mux.
- **Sub-module `debounce_unit`:** parameters `WIDTH` and `DEBOUNCE_CYCLES`. It contains synchronizer, `sync_prev`, counter and `stable`. It is instantiated twice: `WIDTH=16` for the switches and `WIDTH=1` for the button.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `SWITCH_SNAPSHOT_EN` defined.
- **Reset:** assert `rst_n=0` mid-run with switches at `16'hFFFF`, then read offsets `0x0`, `0x2` and `0x4` → all return `16'h0000`; after release, `0x4` reads `16'hFFFF` exactly 7 edges later.
- **Switch latency:** set `sw_raw=16'hA5C3` → offset `0x4` reads the old value through edge 6 and reads `16'hA5C3` from edge 7.
- **Glitch rejection:** pulse bit 0 high for 3 cycles, then return low → offset `0x4` never changes.
- **Snapshot and read-to-clear:** switches `16'h1234`, press button 10 cycles → status reads 1; read `0x0` returns `16'h1234`; status then reads 0.
- **Set wins:** align a `0x0` read with `confirm_pulse` while switches are `16'h5678` and the old snapshot is `16'h1234` → the read returns `16'h1234`, `snap_valid` stays 1, and the next `0x0` read returns `16'h5678`.
- **Chip select and unmapped offsets:** with `SwitchCtrl=0` and `addr_low=0` → `io_rdata=0` and `snap_valid` is unchanged; offset `0x6` → `16'h0000`.
